// File: rtl/clint_mtime_pkg.sv
// Shared constants, FSM state type and address-compare helper for the
// core-local mtime timer. The crossbar's clint branch decodes on CLINT_BASE.
package clint_mtime_pkg;

    localparam logic [31:0] CLINT_BASE   = 32'h0200_0000;
    localparam logic [31:0] MTIME_LO_OFF = 32'h0000_0000;
    localparam logic [31:0] MTIME_HI_OFF = 32'h0000_0004;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Word-granular address match: byte-lane bits [1:0] are ignored.
    function automatic logic word_match(input logic [31:0] addr, input logic [31:0] target);
        return (addr[31:2] == target[31:2]);
    endfunction

endpackage

// File: rtl/clint_mtime_if.sv
// Read-only AXI4 channel subset (AR + R) between the crossbar clint branch
// (master) and the mtime timer (slave).
//   araddr/arvalid/arready : read address channel
//   rdata/rresp/rvalid/rready/rlast : read data channel, single beat
interface clint_mtime_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              rlast;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/clint_mtime_counter.sv
// Free-running 64-bit mtime counter behind a prescaler.
//   i_clock : core clock
//   i_reset : asynchronous active-low reset
//   mtime   : current counter value (register output)
// mtime advances once every PRESCALE core clocks and wraps silently.
module mtime_counter #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [63:0] mtime
);

    localparam int unsigned      PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_d,  pcnt_q;
    logic [63:0]   mtime_d, mtime_q;

    // Next-state: prescaler wraps at PRESCALE-1 and carries into mtime.
    always_comb begin
        pcnt_d  = pcnt_q;
        mtime_d = mtime_q;
        if (pcnt_q == PLAST) begin
            pcnt_d  = {PW{1'b0}};
            mtime_d = mtime_q + 64'd1;
        end else begin
            pcnt_d  = pcnt_q + PW'(1);
        end
    end

    // Counter and prescaler registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pcnt_q  <= {PW{1'b0}};
            mtime_q <= 64'd0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint_mtime.sv
// Core-local timer slave: free-running 64-bit mtime readable over AXI4 reads.
//   i_clock : core clock
//   i_reset : asynchronous active-low reset
//   bus     : AR/R read channels (slave side), single-beat responses
//   o_mtime : live counter value for a future interrupt comparator
// Reading the low word snapshots the high word into shadow_hi so that a
// lo-then-hi read pair yields one coherent 64-bit value.
module clint_mtime
    import clint_mtime_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE,
    parameter int unsigned PRESCALE  = 1,
    parameter int          DATA_W    = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    clint_mtime_if.slave  bus,
    output logic [63:0]   o_mtime
);

    localparam logic [31:0] LO_ADDR = BASE_ADDR + MTIME_LO_OFF;
    localparam logic [31:0] HI_ADDR = BASE_ADDR + MTIME_HI_OFF;

    logic [63:0]       mtime_s;

    state_e            state_d,     state_q;
    logic              arready_d,   arready_q;
    logic              rvalid_d,    rvalid_q;
    logic              rlast_d,     rlast_q;
    logic [DATA_W-1:0] rdata_d,     rdata_q;
    logic [1:0]        rresp_d,     rresp_q;
    logic [31:0]       shadow_hi_d, shadow_hi_q;

    mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .mtime   (mtime_s)
    );

    // FSM next-state, address decode and snapshot update. mtime_s is the
    // register value of the handshake cycle, i.e. the pre-increment value.
    always_comb begin
        state_d     = state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        shadow_hi_d = shadow_hi_q;
        case (state_q)
            IDLE: begin
                if (bus.arvalid) begin
                    state_d   = RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = 1'b1;
                    if (word_match(bus.araddr, LO_ADDR)) begin
                        rdata_d     = mtime_s[31:0];
                        rresp_d     = RESP_OKAY;
                        shadow_hi_d = mtime_s[63:32];
                    end else if (word_match(bus.araddr, HI_ADDR)) begin
                        rdata_d     = shadow_hi_q;
                        rresp_d     = RESP_OKAY;
                    end else begin
                        rdata_d     = {DATA_W{1'b0}};
                        rresp_d     = RESP_SLVERR;
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            RESP: begin
                // Response held stable until the master accepts it.
                if (bus.rready) begin
                    state_d   = IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                end else begin
                    arready_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // Bus-side registers; reset drops any pending response immediately.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            rresp_q     <= 2'b00;
            shadow_hi_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            shadow_hi_q <= shadow_hi_d;
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign o_mtime     = mtime_s;

endmodule

// File: tb/tb_clint_mtime.sv
// Scoreboard bench for clint_mtime: two instances (PRESCALE 1 and 4).
// The reference model derives mtime from the number of clock edges since
// reset release divided by PRESCALE, and keeps its own per-instance snapshot.
`timescale 1ns/1ps
module tb_clint_mtime;
    import clint_mtime_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clint_mtime_if bus1 ();
    clint_mtime_if bus4 ();
    logic [63:0] mt1, mt4;

    clint_mtime #(.BASE_ADDR(CLINT_BASE), .PRESCALE(1), .DATA_W(32)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus1), .o_mtime(mt1));
    clint_mtime #(.BASE_ADDR(CLINT_BASE), .PRESCALE(4), .DATA_W(32)) dut4 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus4), .o_mtime(mt4));

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        q1[$];
    exp_t        q4[$];
    logic [31:0] shadow [2];
    int          n_tests = 0;
    int          n_fail  = 0;
    longint unsigned cyc;

    // Clock edges since reset release; read at an edge it gives the edge index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted response beat against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && bus1.rvalid && bus1.rready) begin
            if (q1.size() == 0) check("p1_unexpected_beat", 64'(q1.size()), 64'd1);
            else begin
                e = q1.pop_front();
                check("p1_rdata", bus1.rdata, e.data);
                check("p1_rresp", bus1.rresp, e.resp);
                check("p1_rlast", bus1.rlast, 1'b1);
            end
        end
        if (rst_n && bus4.rvalid && bus4.rready) begin
            if (q4.size() == 0) check("p4_unexpected_beat", 64'(q4.size()), 64'd1);
            else begin
                e = q4.pop_front();
                check("p4_rdata", bus4.rdata, e.data);
                check("p4_rresp", bus4.rresp, e.resp);
                check("p4_rlast", bus4.rlast, 1'b1);
            end
        end
    end

    // Issue one read from a negedge; returns at the negedge after the handshake.
    task automatic do_read(input int sel, input logic [31:0] addr, input bit ovr, input logic [63:0] ovr_val);
        exp_t            e;
        logic [63:0]     v;
        longint unsigned div;
        bit              done;
        logic            ar;
        done = 1'b0;
        if (sel == 0) begin bus1.araddr = addr; bus1.arvalid = 1'b1; end
        else          begin bus4.araddr = addr; bus4.arvalid = 1'b1; end
        for (int g = 0; g < 20 && !done; g++) begin
            @(posedge clk);
            ar = (sel == 0) ? bus1.arready : bus4.arready;
            if (ar) begin
                div = (sel == 0) ? 64'd1 : 64'd4;
                v   = ovr ? ovr_val : 64'(cyc / div);
                if ((addr & ~32'h3) == CLINT_BASE) begin
                    e.data = v[31:0]; e.resp = RESP_OKAY; shadow[sel] = v[63:32];
                end else if ((addr & ~32'h3) == (CLINT_BASE + 32'd4)) begin
                    e.data = shadow[sel]; e.resp = RESP_OKAY;
                end else begin
                    e.data = 32'd0; e.resp = RESP_SLVERR;
                end
                if (sel == 0) q1.push_back(e); else q4.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
            if (done) begin
                if (sel == 0) bus1.arvalid = 1'b0; else bus4.arvalid = 1'b0;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL ar_handshake_timeout: sel=%0d addr=%h got no arready, expected handshake", sel, addr);
            bus1.arvalid = 1'b0; bus4.arvalid = 1'b0;
        end else begin
            check("rvalid_latency", (sel == 0) ? bus1.rvalid : bus4.rvalid, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          k, d;
        logic [31:0] a, r0, r1;
        shadow[0] = 32'd0; shadow[1] = 32'd0;
        bus1.araddr = 32'd0; bus1.arvalid = 1'b0; bus1.rready = 1'b1;
        bus4.araddr = 32'd0; bus4.arvalid = 1'b0; bus4.rready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_arready", bus1.arready, 1'b1);
        check("rst_rvalid",  bus1.rvalid,  1'b0);
        check("rst_rdata",   bus1.rdata,   32'd0);
        check("rst_rresp",   bus1.rresp,   2'b00);
        check("rst_rlast",   bus1.rlast,   1'b0);
        check("rst_mtime",   mt1,          64'd0);
        rst_n = 1'b1;

        // 1. count since release
        repeat (10) @(negedge clk);
        do_read(0, CLINT_BASE, 1'b0, 64'd0);
        @(negedge clk);

        // 3. backpressure for 7 cycles
        bus1.rready = 1'b0;
        do_read(0, CLINT_BASE, 1'b0, 64'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_rvalid",  bus1.rvalid,  1'b1);
            check("bp_arready", bus1.arready, 1'b0);
            check("bp_rdata",   bus1.rdata,   q1[0].data);
            check("bp_rresp",   bus1.rresp,   q1[0].resp);
            check("bp_rlast",   bus1.rlast,   1'b1);
        end
        bus1.rready = 1'b1;
        @(negedge clk);
        check("bp_idle_rvalid",  bus1.rvalid,  1'b0);
        check("bp_idle_arready", bus1.arready, 1'b1);
        check("bp_idle_rlast",   bus1.rlast,   1'b0);

        // 4. bad addresses leave the snapshot alone
        do_read(0, CLINT_BASE,          1'b0, 64'd0); @(negedge clk);
        do_read(0, CLINT_BASE + 32'd8,  1'b0, 64'd0); @(negedge clk);
        do_read(0, 32'h0000_0000,       1'b0, 64'd0); @(negedge clk);
        do_read(0, CLINT_BASE + 32'd4,  1'b0, 64'd0); @(negedge clk);

        // Randomized reads with random response backpressure
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 5);
            d = $urandom_range(0, 3);
            case (k)
                0:       a = CLINT_BASE;
                1:       a = CLINT_BASE + 32'd4;
                2:       a = CLINT_BASE + 32'd8;
                3:       a = CLINT_BASE + 32'($urandom_range(0, 3));
                4:       a = CLINT_BASE + 32'd4 + 32'($urandom_range(0, 3));
                default: a = $urandom();
            endcase
            bus1.rready = (d == 0);
            do_read(0, a, 1'b0, 64'd0);
            if (d != 0) begin
                repeat (d) @(negedge clk);
                bus1.rready = 1'b1;
            end
            @(negedge clk);
        end

        // 5. PRESCALE=4: lo reads with handshakes 40 cycles apart
        do_read(1, CLINT_BASE, 1'b0, 64'd0);
        r0 = bus4.rdata;
        repeat (39) @(negedge clk);
        do_read(1, CLINT_BASE, 1'b0, 64'd0);
        r1 = bus4.rdata;
        check("prescale_delta", 64'(r1 - r0), 64'd10);
        @(negedge clk);

        // 2. carry coherency across a lo-then-hi pair
        force dut1.u_cnt.mtime_q = 64'h0000_0000_FFFF_FFFE;
        do_read(0, CLINT_BASE, 1'b1, 64'h0000_0000_FFFF_FFFE);
        release dut1.u_cnt.mtime_q;
        repeat (5) @(negedge clk);
        do_read(0, CLINT_BASE + 32'd4, 1'b0, 64'd0);
        check("carry_live_hi", mt1[63:32], 32'd1);
        @(negedge clk);

        // 6. reset while a response is pending
        bus1.rready = 1'b0;
        do_read(0, CLINT_BASE, 1'b0, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rvalid",  bus1.rvalid,  1'b0);
        check("arst_arready", bus1.arready, 1'b1);
        check("arst_mtime",   mt1,          64'd0);
        check("arst_mtime4",  mt4,          64'd0);
        void'(q1.pop_back());
        shadow[0] = 32'd0; shadow[1] = 32'd0;
        bus1.rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(0, CLINT_BASE + 32'd4, 1'b0, 64'd0); @(negedge clk);
        do_read(0, CLINT_BASE,         1'b0, 64'd0); @(negedge clk);
        do_read(0, CLINT_BASE + 32'd4, 1'b0, 64'd0); @(negedge clk);
        do_read(1, CLINT_BASE + 32'd4, 1'b0, 64'd0); @(negedge clk);

        repeat (3) @(negedge clk);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
